// File: rtl/y86_mem_pkg.sv
// y86_mem_pkg: shared IO map, STATUS bit layout and helpers for the y86 bus responder
package y86_mem_pkg;

   localparam logic [31:0] IO_TXDATA    = 32'h8000_0000;
   localparam logic [31:0] IO_STATUS    = 32'h8000_0004;
   localparam int          IO_SEL_BIT   = 31;

   localparam int          ST_EMPTY     = 1;
   localparam int          ST_FULL      = 2;
   localparam int          ST_COUNT_LSB = 3;
   localparam int          ST_OVF       = 7;

   // Packs the console state into the STATUS read word
   function automatic logic [31:0] status_word(
      input logic       ovf,
      input logic [3:0] cnt,
      input logic       full,
      input logic       empty
   );
      logic [31:0] w;
      w                       = '0;
      w[ST_OVF]               = ovf;
      w[ST_COUNT_LSB +: 4]    = cnt;
      w[ST_FULL]              = full;
      w[ST_EMPTY]             = empty;
      return w;
   endfunction

endpackage

// File: rtl/y86_con_fifo.sv
// y86_con_fifo: byte FIFO for the console, accepts a push into a full FIFO when a pop frees a slot
module y86_con_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [7:0]               i_data,
   input  logic                     i_pop,
   output logic [7:0]               o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_accept
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_cnt;
   logic          w_pop;
   logic          w_push;

   assign o_count  = r_cnt;
   assign o_empty  = r_cnt == '0;
   assign o_full   = r_cnt == CW'(DEPTH);
   assign w_pop    = i_pop && !o_empty;
   assign o_accept = !o_full || w_pop;
   assign w_push   = i_push && o_accept;
   // Head byte is forced to zero when empty so stale storage never leaks out
   assign o_data   = o_empty ? 8'h00 : r_mem[r_rd];

   // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         r_wr  <= w_push ? r_wr + AW'(1) : r_wr;
         r_rd  <= w_pop  ? r_rd + AW'(1) : r_rd;
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end

   // Storage is left unreset; validity is tracked by the count
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

endmodule

// File: rtl/y86_bus_mem.sv
// y86_bus_mem: byte RAM plus console TX FIFO behind the y86 core bus; console gated by Y86_MEM_CONSOLE_EN
module y86_bus_mem
   import y86_mem_pkg::*;
#(
   parameter int    ADDR_W     = 12,
   parameter int    FIFO_DEPTH = 8,
   parameter string INIT_FILE  = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bus_A,
   input  logic [31:0] bus_out,
   input  logic        bus_WE,
   input  logic        bus_RE,
   output logic [31:0] bus_in,
   output logic [7:0]  con_data,
   output logic        con_valid,
   input  logic        con_ready,
   output logic        bus_err
);

   logic [7:0]        r_mem [2**ADDR_W];
   logic [ADDR_W-1:0] w_a0;
   logic [ADDR_W-1:0] w_a1;
   logic [ADDR_W-1:0] w_a2;
   logic [ADDR_W-1:0] w_a3;
   logic              w_is_io;
   logic              w_ram_we;
   logic [31:0]       w_ram_rd;
   logic [31:0]       w_io_rd;

   assign w_is_io  = bus_A[IO_SEL_BIT];
   assign w_ram_we = bus_WE && !w_is_io;
   assign w_a0     = bus_A[ADDR_W-1:0];
   assign w_a1     = w_a0 + ADDR_W'(1);
   assign w_a2     = w_a0 + ADDR_W'(2);
   assign w_a3     = w_a0 + ADDR_W'(3);

   always_comb begin
      w_ram_rd = {r_mem[w_a3], r_mem[w_a2], r_mem[w_a1], r_mem[w_a0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (!rst && w_ram_we) begin
         r_mem[w_a0] <= bus_out[7:0];
         r_mem[w_a1] <= bus_out[15:8];
         r_mem[w_a2] <= bus_out[23:16];
         r_mem[w_a3] <= bus_out[31:24];
      end
   end

`ifdef Y86_MEM_CONSOLE_EN
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          w_sel_tx;
   logic          w_sel_st;
   logic          w_push;
   logic          w_accept;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic [3:0]    w_cnt_sat;
   logic          r_ovf;
   logic          r_err;

   assign w_sel_tx  = bus_A == IO_TXDATA;
   assign w_sel_st  = bus_A == IO_STATUS;
   assign w_push    = bus_WE && w_sel_tx;
   assign w_cnt_sat = (32'(w_count) > 32'd15) ? 4'hF : 4'(w_count);

   y86_con_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (bus_out[7:0]),
      .i_pop   (con_ready),
      .o_data  (con_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count),
      .o_accept(w_accept)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_ovf <= (bus_WE && w_sel_st) ? 1'b0 : (w_push && !w_accept) ? 1'b1 : r_ovf;
         r_err <= bus_WE && w_is_io && !w_sel_tx && !w_sel_st;
      end
   end

   assign w_io_rd   = w_sel_st ? status_word(r_ovf, w_cnt_sat, w_full, w_empty) : '0;
   assign con_valid = !w_empty;
   assign bus_err   = r_err;
`else
   logic w_unused;

   assign w_unused  = &{1'b0, con_ready, bus_A[30:ADDR_W]};
   assign w_io_rd   = '0;
   assign con_valid = 1'b0;
   assign con_data  = 8'h00;
   assign bus_err   = 1'b0;
`endif

   assign bus_in = !bus_RE ? '0 : w_is_io ? w_io_rd : w_ram_rd;

endmodule

// File: tb/tb_y86_bus_mem.sv
// tb_y86_bus_mem: directed table plus multi-cycle sequences for the y86 bus responder
module tb_y86_bus_mem;

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

`ifdef Y86_MEM_CONSOLE_EN
   localparam bit CON = 1'b1;
`else
   localparam bit CON = 1'b0;
`endif

   localparam logic [31:0] TX = 32'h8000_0000;
   localparam logic [31:0] ST = 32'h8000_0004;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bus_A;
   logic [31:0] bus_out;
   logic        bus_WE;
   logic        bus_RE;
   logic [31:0] bus_in;
   logic [7:0]  con_data;
   logic        con_valid;
   logic        con_ready;
   logic        bus_err;
   int          n_chk  = 0;
   int          n_fail = 0;
   vec_t        tv[$];

   always #5 clk = ~clk;

   y86_bus_mem dut (
      .clk      (clk),
      .rst      (rst),
      .bus_A    (bus_A),
      .bus_out  (bus_out),
      .bus_WE   (bus_WE),
      .bus_RE   (bus_RE),
      .bus_in   (bus_in),
      .con_data (con_data),
      .con_valid(con_valid),
      .con_ready(con_ready),
      .bus_err  (bus_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic re, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] exp);
      vec_t v;
      v.we  = we;
      v.re  = re;
      v.a   = a;
      v.d   = d;
      v.exp = exp;
      return v;
   endfunction

   task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
      bus_WE  = we;
      bus_RE  = re;
      bus_A   = a;
      bus_out = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_cyc(input logic [31:0] a, input logic [31:0] d);
      drive(1'b1, 1'b0, a, d);
      step();
   endtask

   task automatic rd_cyc(input string name, input logic [31:0] a, input logic [31:0] exp);
      drive(1'b0, 1'b1, a, 32'h0);
      @(negedge clk);
      chk(name, bus_in, exp);
      step();
   endtask

   initial begin
      logic [7:0] drain [8];
      rst       = 1'b1;
      con_ready = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      #12;
      chk("rst_con_valid", 32'(con_valid), 32'h0);
      chk("rst_con_data", 32'(con_data), 32'h0);
      chk("rst_bus_err", 32'(bus_err), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd_cyc("status_after_rst", ST, CON ? 32'h02 : 32'h0);

      tv.push_back(mk(1, 0, 32'h0000_0000, 32'h0000_AA55, 32'h0));
      tv.push_back(mk(1, 0, 32'h0000_0104, 32'h0000_7700, 32'h0));
      tv.push_back(mk(1, 0, 32'h0000_0101, 32'hDEAD_BEEF, 32'h0));
      tv.push_back(mk(0, 1, 32'h0000_0101, 32'h0,         32'hDEAD_BEEF));
      tv.push_back(mk(0, 1, 32'h0000_0102, 32'h0,         32'h77DE_ADBE));
      tv.push_back(mk(1, 0, 32'h0000_0FFE, 32'h1122_3344, 32'h0));
      tv.push_back(mk(0, 1, 32'h0000_0FFE, 32'h0,         32'h1122_3344));
      tv.push_back(mk(0, 1, 32'h0000_0000, 32'h0,         32'h0000_1122));
      tv.push_back(mk(0, 1, 32'h0000_0FFF, 32'h0,         32'h0011_2233));
      tv.push_back(mk(0, 1, 32'h7000_0101, 32'h0,         32'hDEAD_BEEF));
      tv.push_back(mk(0, 0, 32'h0000_0101, 32'h0,         32'h0));
      tv.push_back(mk(1, 1, 32'h0000_0101, 32'h0102_0304, 32'hDEAD_BEEF));
      tv.push_back(mk(0, 1, 32'h0000_0101, 32'h0,         32'h0102_0304));
      tv.push_back(mk(0, 1, 32'h8000_0010, 32'h0,         32'h0));
      tv.push_back(mk(0, 1, TX,            32'h0,         32'h0));
      tv.push_back(mk(1, 0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0));
      tv.push_back(mk(1, 0, 32'h0000_0020, 32'h0BAD_C0DE, 32'h0));
      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].we, tv[i].re, tv[i].a, tv[i].d);
         @(negedge clk);
         chk($sformatf("vec%0d_bus_in", i), bus_in, tv[i].exp);
         step();
      end

      wr_cyc(32'h8000_0010, 32'h1234_5678);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("err_pulse_hi", 32'(bus_err), 32'(CON));
      step();
      @(negedge clk);
      chk("err_pulse_lo", 32'(bus_err), 32'h0);
      step();
      rd_cyc("err_ram_untouched", 32'h0000_0010, 32'hCAFE_F00D);

      for (int k = 0; k < 8; k++) wr_cyc(TX, 32'h41 + 32'(k));
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("fill_valid", 32'(con_valid), 32'(CON));
      chk("fill_head", 32'(con_data), CON ? 32'h41 : 32'h0);
      chk("fill_no_err", 32'(bus_err), 32'h0);
      step();
      rd_cyc("status_full", ST, CON ? 32'h44 : 32'h0);
      wr_cyc(TX, 32'h49);
      rd_cyc("status_ovf", ST, CON ? 32'hC4 : 32'h0);
      wr_cyc(ST, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("status_wr_no_err", 32'(bus_err), 32'h0);
      step();
      rd_cyc("status_ovf_clr", ST, CON ? 32'h44 : 32'h0);

      con_ready = 1'b1;
      wr_cyc(TX, 32'h5A);
      con_ready = 1'b0;
      rd_cyc("status_push_pop", ST, CON ? 32'h44 : 32'h0);
`ifdef Y86_MEM_CONSOLE_EN
      drain = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h5A};
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      con_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("drain%0d", i), 32'(con_data), 32'(drain[i]));
         step();
      end
      con_ready = 1'b0;
      @(negedge clk);
      chk("drain_empty", 32'(con_valid), 32'h0);
      step();
`endif

      for (int k = 0; k < 3; k++) wr_cyc(TX, 32'h61 + 32'(k));
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("pre_rst_valid", 32'(con_valid), 32'(CON));
      step();
      drive(1'b1, 1'b0, 32'h0000_0020, 32'hFFFF_FFFF);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(con_valid), 32'h0);
      chk("async_rst_data", 32'(con_data), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      rd_cyc("status_post_rst", ST, CON ? 32'h02 : 32'h0);
      rd_cyc("rst_write_dropped", 32'h0000_0020, 32'h0BAD_C0DE);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
